lif_neuron_layer: RTL and testbench

Time-stepped leaky integrate-and-fire layer, the compute core directly below the tt_um_NeuroCore pin wrapper. On each `step` strobe it samples N_IN input spikes and processes the N_OUT neurons one at a time:
- weighted accumulation, one input per cycle;
- leak, saturating integrate, threshold compare, refractory handling.

It then presents a registered spike vector. Weights and threshold come from a simple write port driven by the wrapper's configuration logic.

---
 rtl/lif_neuron_layer.sv | 186 ++++++++++++++++++
 tb/tb_lif_neuron_layer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_layer.sv
// Time-stepped leaky integrate-and-fire layer: per step, neurons are processed
// serially (N_IN accumulate cycles + 1 update cycle each), then spikes are published.
module lif_neuron_layer #(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 4,
  parameter int W_WIDTH    = 4,
  parameter int V_WIDTH    = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int THR_RESET  = 10,
  localparam int N_W = N_IN * N_OUT,
  localparam int AW  = (N_W > 1) ? $clog2(N_W) : 1,
  localparam int SW  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we_i,
  input  logic               cfg_sel_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [V_WIDTH-1:0] cfg_data_i,
  input  logic               step_i,
  input  logic [N_IN-1:0]    spike_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_OUT-1:0]   spike_out_o,
  input  logic [SW-1:0]      vmem_sel_i,
  output logic [V_WIDTH-1:0] vmem_out_o
);

  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int RW   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int ACCW = V_WIDTH + 2;
  localparam int SUMW = V_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_e;

  state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [SW-1:0] j_q, j_d;

  logic signed [W_WIDTH-1:0] w_q [N_W];
  logic [V_WIDTH-1:0]        thr_q;
  logic [V_WIDTH-1:0]        v_q [N_OUT];
  logic [RW-1:0]             refrac_q [N_OUT];
  logic [N_IN-1:0]           spikes_lat_q;
  logic signed [ACCW-1:0]    acc_q;
  logic [N_OUT-1:0]          spike_vec_q, spike_vec_d;
  logic [N_OUT-1:0]          spike_out_q;
  logic [V_WIDTH-1:0]        vmem_q;

  logic [AW-1:0]             w_idx;
  logic signed [W_WIDTH-1:0] w_cur;
  logic signed [ACCW-1:0]    w_ext;
  logic [V_WIDTH-1:0]        v_cur, vl;
  logic signed [SUMW-1:0]    s_wide;
  logic [V_WIDTH-1:0]        s_sat;
  logic                      in_refrac, fire;
  logic                      last_i, last_j;

  assign last_i = (i_q == IW'(N_IN - 1));
  assign last_j = (j_q == SW'(N_OUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: if (step_i) begin
        state_d = ACCUM;
        i_d     = '0;
        j_d     = '0;
      end
      ACCUM: begin
        i_d = i_q + IW'(1);
        if (last_i) begin
          i_d     = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (last_j) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + SW'(1);
          state_d = ACCUM;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leak, saturating integrate and threshold compare for the neuron in flight.
  always_comb begin
    w_idx     = AW'(int'(j_q) * N_IN + int'(i_q));
    w_cur     = w_q[w_idx];
    w_ext     = {{(ACCW - W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    v_cur     = v_q[j_q];
    vl        = v_cur - (v_cur >> LEAK_SHIFT);
    s_wide    = $signed({3'b000, vl}) + $signed({acc_q[ACCW-1], acc_q});
    if (s_wide[SUMW-1])
      s_sat = '0;
    else if (s_wide[SUMW-2:V_WIDTH] != '0)
      s_sat = '1;
    else
      s_sat = s_wide[V_WIDTH-1:0];
    in_refrac = (refrac_q[j_q] != '0);
    fire      = !in_refrac && (s_sat >= thr_q);
    spike_vec_d       = spike_vec_q;
    spike_vec_d[j_q]  = fire;
  end

  // NOTE: the weight and membrane arrays are reset explicitly because the
  // layer must come up with zero weights and zero potentials; this costs a
  // flop-based store instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_W; k++) w_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        v_q[k]      <= '0;
        refrac_q[k] <= '0;
      end
      thr_q        <= V_WIDTH'(THR_RESET);
      spikes_lat_q <= '0;
      acc_q        <= '0;
      spike_vec_q  <= '0;
      spike_out_q  <= '0;
      vmem_q       <= '0;
    end else begin
      if (cfg_we_i && state_q == IDLE) begin
        if (cfg_sel_i)
          thr_q <= cfg_data_i;
        else if ({1'b0, cfg_addr_i} < (AW + 1)'(N_W))
          w_q[cfg_addr_i] <= cfg_data_i[W_WIDTH-1:0];
      end

      unique case (state_q)
        IDLE: if (step_i) begin
          spikes_lat_q <= spike_in_i;
          acc_q        <= '0;
          spike_vec_q  <= '0;
        end
        ACCUM: if (spikes_lat_q[i_q]) acc_q <= acc_q + w_ext;
        UPDATE: begin
          acc_q <= '0;
          if (in_refrac) begin
            refrac_q[j_q] <= refrac_q[j_q] - RW'(1);
            v_q[j_q]      <= '0;
          end else if (fire) begin
            refrac_q[j_q] <= RW'(REFRAC);
            v_q[j_q]      <= '0;
          end else begin
            v_q[j_q] <= s_sat;
          end
          spike_vec_q <= spike_vec_d;
          if (last_j) spike_out_q <= spike_vec_d;
        end
        default: ;
      endcase

      vmem_q <= v_q[vmem_sel_i];
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign spike_out_o = spike_out_q;
  assign vmem_out_o  = vmem_q;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Scoreboard bench for lif_neuron_layer: stimulus pushes expected spikes and
// membrane values; a monitor pops and compares on every done pulse.
module tb_lif_neuron_layer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_sel;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       step;
  logic [7:0] spike_in;
  logic       busy, done;
  logic [3:0] spike_out;
  logic [1:0] vmem_sel;
  logic [7:0] vmem_out;

  typedef struct packed {
    logic [3:0] spk;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lif_neuron_layer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we_i   (cfg_we),
    .cfg_sel_i  (cfg_sel),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .step_i     (step),
    .spike_in_i (spike_in),
    .busy_o     (busy),
    .done_o     (done),
    .spike_out_o(spike_out),
    .vmem_sel_i (vmem_sel),
    .vmem_out_o (vmem_out)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: spike vector on the done cycle, membrane one cycle later.
  initial begin
    exp_t e;
    logic [3:0] got_spk;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_spk = spike_out;
        @(negedge clk);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("spike_out", int'(got_spk), int'(e.spk));
          check("vmem", int'(vmem_out), int'(e.v));
        end
      end
    end
  end

  task automatic cfg_write(input logic sel, input int addr, input logic [7:0] data);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 5'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // One timestep; checks busy length and done position. With interfere set,
  // a weight write plus step pulse mid-step and a step pulse during DONE.
  task automatic do_step(input logic [7:0] spk, input logic [3:0] exp_spk,
                         input logic [1:0] vsel, input logic [7:0] exp_v,
                         input bit interfere);
    int busy_cnt = 0;
    int done_pos = 0;
    vmem_sel = vsel;
    sb.push_back('{spk: exp_spk, v: exp_v});
    @(posedge clk); #1;
    step = 1'b1; spike_in = spk;
    @(posedge clk); #1;
    step = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (interfere && (c == 5 || c == 37)) begin
        step = 1'b1;
        if (c == 5) begin
          cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = 8'h01;
        end
      end else begin
        step = 1'b0; cfg_we = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done && done_pos == 0) done_pos = c;
      if (!busy) break;
    end
    check("busy_cycles", busy_cnt, 37);
    check("done_position", done_pos, 37);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    step = 1'b0; spike_in = '0; vmem_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_spike_out", int'(spike_out), 0);
    check("rst_vmem", int'(vmem_out), 0);

    // Zero weights: no spikes, potentials stay 0.
    do_step(8'hFF, 4'h0, 2'd0, 8'd0, 1'b0);

    // Single excitatory synapse, threshold 10, refractory 2.
    cfg_write(1'b0, 0, 8'h07);
    do_step(8'h01, 4'h0, 2'd0, 8'd7,  1'b0);
    do_step(8'h01, 4'h1, 2'd0, 8'd0,  1'b0);
    do_step(8'h01, 4'h0, 2'd0, 8'd0,  1'b0);
    do_step(8'h01, 4'h0, 2'd0, 8'd0,  1'b0);
    do_step(8'h01, 4'h0, 2'd0, 8'd7,  1'b0);

    // Neuron 2 fully inhibitory: clamps at 0; neuron 0 fires (7 + 7 = 14).
    for (int i = 0; i < 8; i++) cfg_write(1'b0, 16 + i, 8'h08);
    do_step(8'hFF, 4'h1, 2'd2, 8'd0, 1'b0);

    // Neuron 1: +7 on all inputs, threshold 255, climbs then saturates.
    for (int i = 0; i < 8; i++) cfg_write(1'b0, 8 + i, 8'h07);
    cfg_write(1'b1, 0, 8'd255);
    do_step(8'hFF, 4'h0, 2'd1, 8'd56,  1'b0);
    do_step(8'hFF, 4'h0, 2'd1, 8'd105, 1'b0);
    do_step(8'hFF, 4'h0, 2'd1, 8'd148, 1'b0);
    do_step(8'hFF, 4'h0, 2'd1, 8'd186, 1'b0);
    do_step(8'hFF, 4'h0, 2'd1, 8'd219, 1'b0);
    do_step(8'hFF, 4'h0, 2'd1, 8'd248, 1'b0);
    do_step(8'hFF, 4'h2, 2'd1, 8'd0,   1'b0);

    // Neuron 0 sits at 29: step and cfg writes while busy must be ignored.
    do_step(8'h01, 4'h0, 2'd0, 8'd33, 1'b1);
    do_step(8'h01, 4'h0, 2'd0, 8'd36, 1'b0);

    // Reset ten cycles into a step aborts it with no done pulse.
    vmem_sel = 2'd1;
    @(posedge clk); #1;
    step = 1'b1; spike_in = 8'hFF;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_spike_out", int'(spike_out), 0);
    check("abort_vmem", int'(vmem_out), 0);
    dones = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1 vmem_sel = 2'(s);
      @(negedge clk); @(negedge clk);
      check("abort_vmem_sel", int'(vmem_out), 0);
    end

    // Weights were cleared by the reset.
    do_step(8'hFF, 4'h0, 2'd0, 8'd0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
